// File: rtl/bus_arb_if.sv
// Bundled master/slave-side signals of the two-master arbiter.
// The arbiter uses the slave modport; the surrounding environment uses the master modport.
interface bus_arb_if #(
    parameter int AW = 16,
    parameter int DW = 8
);
    logic          m0_valid, m1_valid;
    logic          m0_write, m1_write;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic          m0_ready, m1_ready;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic          s_valid, s_write;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata;
    logic          s_ready;
    logic [DW-1:0] s_rdata;
    logic          owner, busy, err, err_clr;

    modport slave (
        input  m0_valid, m1_valid, m0_write, m1_write, m0_addr, m1_addr,
               m0_wdata, m1_wdata, s_ready, s_rdata, err_clr,
        output m0_ready, m1_ready, m0_rdata, m1_rdata,
               s_valid, s_write, s_addr, s_wdata, owner, busy, err
    );

    modport master (
        output m0_valid, m1_valid, m0_write, m1_write, m0_addr, m1_addr,
               m0_wdata, m1_wdata, s_ready, s_rdata, err_clr,
        input  m0_ready, m1_ready, m0_rdata, m1_rdata,
               s_valid, s_write, s_addr, s_wdata, owner, busy, err
    );
endinterface

// File: rtl/bus_arb.sv
// Two-master round-robin arbiter for the four-phase valid/ready bus, holding each
// grant for a whole transfer, with a watchdog that aborts transfers the slave never acks.
module bus_arb #(
    parameter int AW  = 16,
    parameter int DW  = 8,
    parameter int TMO = 255
) (
    input  logic       clk,
    input  logic       rstb,
    bus_arb_if.slave   bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, REL = 2'd2, ABT = 2'd3} st_t;

    localparam logic [15:0] TMO_LAST = 16'(TMO - 1);

    st_t           st_q, st_d;
    logic          owner_q, owner_d;
    logic          err_q, err_d;
    logic [15:0]   tcnt_q, tcnt_d;

    logic          own_valid_s;
    logic          own_ready_s;
    logic [DW-1:0] own_rdata_s;
    logic          s_valid_s;
    logic          err_set_s;
    logic [AW-1:0] s_addr_s;

    assign own_valid_s = owner_q ? bus.m1_valid : bus.m0_valid;
    assign s_addr_s    = owner_q ? bus.m1_addr  : bus.m0_addr;

    // Next-state, arbitration, watchdog and owner-side handshake
    always_comb begin
        st_d        = st_q;
        owner_d     = owner_q;
        tcnt_d      = tcnt_q;
        err_set_s   = 1'b0;
        s_valid_s   = 1'b0;
        own_ready_s = 1'b0;
        own_rdata_s = {DW{1'b0}};
        case (st_q)
            IDLE: begin
                tcnt_d = 16'd0;
                if (bus.m0_valid || bus.m1_valid) begin
                    st_d = REQ;
                    // On a tie the previous owner yields
                    if (bus.m0_valid && bus.m1_valid) begin
                        owner_d = ~owner_q;
                    end else begin
                        owner_d = bus.m1_valid;
                    end
                end else begin
                    st_d = IDLE;
                end
            end
            REQ: begin
                s_valid_s   = own_valid_s;
                own_ready_s = bus.s_ready;
                own_rdata_s = bus.s_rdata;
                if (bus.s_ready) begin
                    st_d = REL;
                end else if (tcnt_q == TMO_LAST) begin
                    st_d      = ABT;
                    err_set_s = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + 16'd1;
                end
            end
            REL: begin
                own_ready_s = own_valid_s | bus.s_ready;
                own_rdata_s = bus.s_rdata;
                if (!own_valid_s && !bus.s_ready) begin
                    st_d = IDLE;
                end else begin
                    st_d = REL;
                end
            end
            ABT: begin
                own_ready_s = 1'b1;
                own_rdata_s = {DW{1'b1}};
                if (!own_valid_s && !bus.s_ready) begin
                    st_d = IDLE;
                end else begin
                    st_d = ABT;
                end
            end
            default: begin
                st_d = IDLE;
            end
        endcase

        // A new timeout overrides a clear request in the same cycle
        if (err_set_s) begin
            err_d = 1'b1;
        end else if (bus.err_clr) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    // State, owner, error flag and watchdog counter registers
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            st_q    <= IDLE;
            owner_q <= 1'b1;
            err_q   <= 1'b0;
            tcnt_q  <= 16'd0;
        end else begin
            st_q    <= st_d;
            owner_q <= owner_d;
            err_q   <= err_d;
            tcnt_q  <= tcnt_d;
        end
    end

    assign bus.s_valid  = s_valid_s;
    assign bus.s_addr   = s_addr_s;
    assign bus.s_write  = owner_q ? bus.m1_write : bus.m0_write;
    assign bus.s_wdata  = owner_q ? bus.m1_wdata : bus.m0_wdata;
    assign bus.m0_ready = ~owner_q & own_ready_s;
    assign bus.m1_ready = owner_q & own_ready_s;
    assign bus.m0_rdata = owner_q ? {DW{1'b0}} : own_rdata_s;
    assign bus.m1_rdata = owner_q ? own_rdata_s : {DW{1'b0}};
    assign bus.owner    = owner_q;
    assign bus.busy     = (st_q != IDLE);
    assign bus.err      = err_q;
endmodule

// File: tb/tb_bus_arb.sv
// Self-checking bench for bus_arb: transaction-level reference model checked every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_bus_arb;
    localparam int AW  = 16;
    localparam int DW  = 8;
    localparam int TMO = 8;

    logic clk  = 1'b0;
    logic rstb = 1'b0;
    always #5 clk = ~clk;

    bus_arb_if #(.AW(AW), .DW(DW)) bus ();
    bus_arb #(.AW(AW), .DW(DW), .TMO(TMO)) dut (.clk(clk), .rstb(rstb), .bus(bus));

    int n_chk  = 0;
    int n_pass = 0;

    // stimulus knobs
    bit auto_m [2];
    bit fix_pl   = 1'b0;
    bit fix_rd   = 1'b0;
    int req_pct  = 0;
    int s_pct    = 100;
    int hold_fix = 0;

    // reference model: granted master (-1 none), last owner, transfer progress
    int gm      = -1;
    bit last    = 1'b1;
    bit acked   = 1'b0;
    bit aborted = 1'b0;
    bit merr    = 1'b0;
    int waited  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic bit get_v(input int i);
        return (i == 1) ? bus.m1_valid : bus.m0_valid;
    endfunction

    task automatic set_m(input int i, input bit v, input bit w, input logic [15:0] a, input logic [7:0] d);
        if (i == 1) begin
            bus.m1_valid = v; bus.m1_write = w; bus.m1_addr = a; bus.m1_wdata = d;
        end else begin
            bus.m0_valid = v; bus.m0_write = w; bus.m0_addr = a; bus.m0_wdata = d;
        end
    endtask

    task automatic set_v(input int i, input bit v);
        if (i == 1) bus.m1_valid = v;
        else bus.m0_valid = v;
    endtask

    task automatic model_step();
        bit v0 = bus.m0_valid;
        bit v1 = bus.m1_valid;
        bit sr = bus.s_ready;
        bit abort_now = 1'b0;
        if (gm < 0) begin
            if (v0 || v1) begin
                if (v0 && v1) gm = last ? 0 : 1;
                else gm = v1 ? 1 : 0;
                last   = (gm == 1);
                waited = 0;
            end
        end else if (!acked && !aborted) begin
            if (sr) acked = 1'b1;
            else if (waited + 1 == TMO) begin
                aborted   = 1'b1;
                abort_now = 1'b1;
            end else waited++;
        end else if (!(gm == 1 ? v1 : v0) && !sr) begin
            gm = -1; acked = 1'b0; aborted = 1'b0;
        end
        if (abort_now) merr = 1'b1;
        else if (bus.err_clr) merr = 1'b0;
    endtask

    task automatic check_model();
        bit ov = last ? bus.m1_valid : bus.m0_valid;
        bit sr = bus.s_ready;
        bit e_sv = 1'b0;
        bit e_r  = 1'b0;
        logic [7:0] e_rd = 8'h00;
        if (gm >= 0) begin
            if (aborted) begin e_r = 1'b1; e_rd = 8'hFF; end
            else if (acked) begin e_r = ov | sr; e_rd = bus.s_rdata; end
            else begin e_sv = ov; e_r = sr; e_rd = bus.s_rdata; end
        end
        chk("s_valid", bus.s_valid, e_sv);
        chk("s_addr", bus.s_addr, last ? bus.m1_addr : bus.m0_addr);
        chk("s_write", bus.s_write, last ? bus.m1_write : bus.m0_write);
        chk("s_wdata", bus.s_wdata, last ? bus.m1_wdata : bus.m0_wdata);
        chk("m0_ready", bus.m0_ready, (gm == 0) ? e_r : 1'b0);
        chk("m1_ready", bus.m1_ready, (gm == 1) ? e_r : 1'b0);
        chk("m0_rdata", bus.m0_rdata, (gm == 0) ? e_rd : 8'h00);
        chk("m1_rdata", bus.m1_rdata, (gm == 1) ? e_rd : 8'h00);
        chk("owner", bus.owner, last);
        chk("busy", bus.busy, gm >= 0);
        chk("err", bus.err, merr);
    endtask

    // model update on every clock edge, reset asynchronously
    initial forever begin
        @(posedge clk or negedge rstb);
        if (!rstb) begin
            gm = -1; last = 1'b1; acked = 1'b0; aborted = 1'b0; merr = 1'b0; waited = 0;
        end else begin
            model_step();
        end
    end

    // per-cycle comparison against the model, away from the active edge
    initial forever begin
        @(negedge clk);
        check_model();
    end

    // slave: ready registered from valid, with optional random stall
    initial begin
        bit sv;
        forever begin
            @(negedge clk);
            sv = bus.s_valid;
            @(posedge clk);
            #1;
            if (!sv) bus.s_ready = 1'b0;
            else if (!bus.s_ready && $urandom_range(99) < s_pct) begin
                bus.s_ready = 1'b1;
                bus.s_rdata = fix_rd ? 8'h5A : 8'($urandom);
            end
        end
    end

    task automatic master_run(input int i);
        bit rdy;
        int hold = 0;
        forever begin
            @(negedge clk);
            rdy = (i == 1) ? bus.m1_ready : bus.m0_ready;
            @(posedge clk);
            #1;
            if (auto_m[i]) begin
                if (!get_v(i)) begin
                    if (!rdy && $urandom_range(99) < req_pct) begin
                        hold = (hold_fix >= 0) ? hold_fix : int'($urandom_range(2));
                        if (fix_pl) set_m(i, 1'b1, 1'b1, (i == 1) ? 16'h2008 : 16'h2007, (i == 1) ? 8'h22 : 8'h11);
                        else set_m(i, 1'b1, 1'($urandom), 16'($urandom), 8'($urandom));
                    end
                end else if (rdy) begin
                    if (hold > 0) hold--;
                    else set_v(i, 1'b0);
                end
            end
        end
    endtask

    initial master_run(0);
    initial master_run(1);

    task automatic wait_busy(input bit lvl, input int max, input string nm);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.busy !== lvl && n < max);
        chk(nm, bus.busy, lvl);
    endtask

    task automatic quiesce();
        int n = 0;
        req_pct = 0;
        s_pct   = 100;
        do begin
            cyc();
            n++;
        end while ((bus.busy || bus.m0_valid || bus.m1_valid) && n < 300);
        chk("quiesce", {bus.busy, bus.m0_valid, bus.m1_valid}, 3'b000);
        auto_m[0] = 1'b0;
        auto_m[1] = 1'b0;
    endtask

    task automatic do_reset();
        rstb = 1'b0;
        repeat (2) cyc();
        rstb = 1'b1;
    endtask

    initial begin
        int cnt;
        auto_m[0] = 1'b0;
        auto_m[1] = 1'b0;
        set_m(0, 1'b0, 1'b0, 16'h0000, 8'h00);
        set_m(1, 1'b0, 1'b0, 16'h0000, 8'h00);
        bus.s_ready = 1'b0;
        bus.s_rdata = 8'h00;
        bus.err_clr = 1'b0;

        // reset state
        repeat (2) cyc();
        @(negedge clk);
        chk("rst_owner", bus.owner, 1'b1);
        chk("rst_outs", {bus.s_valid, bus.m0_ready, bus.m1_ready, bus.busy, bus.err}, 5'b00000);
        cyc();
        rstb = 1'b1;

        // single master 0 read
        fix_rd = 1'b1;
        cyc();
        set_m(0, 1'b1, 1'b0, 16'h2006, 8'h00);
        @(negedge clk);
        chk("t1_wait", bus.s_valid, 1'b0);
        @(negedge clk);
        chk("t1_svalid", bus.s_valid, 1'b1);
        chk("t1_saddr", bus.s_addr, 16'h2006);
        @(negedge clk);
        chk("t1_m0_ready", bus.m0_ready, 1'b1);
        chk("t1_m0_rdata", bus.m0_rdata, 8'h5A);
        chk("t1_m1_ready", bus.m1_ready, 1'b0);
        cyc();
        set_v(0, 1'b0);
        wait_busy(1'b0, 6, "t1_idle");
        fix_rd = 1'b0;

        // both masters continuously after reset: grants alternate
        quiesce();
        do_reset();
        fix_pl = 1'b1; hold_fix = 0; req_pct = 100;
        auto_m[0] = 1'b1; auto_m[1] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_busy(1'b1, 20, "t2_grant");
            chk("t2_owner", bus.owner, k % 2);
            chk("t2_saddr", bus.s_addr, (k % 2) ? 16'h2008 : 16'h2007);
            wait_busy(1'b0, 20, "t2_release");
        end

        // master 1 first, master 0 arrives during its transfer
        quiesce();
        req_pct = 100;
        auto_m[1] = 1'b1;
        wait_busy(1'b1, 20, "t3_grant1");
        chk("t3_owner1", bus.owner, 1'b1);
        auto_m[0] = 1'b1;
        wait_busy(1'b0, 20, "t3_release");
        wait_busy(1'b1, 20, "t3_grant0");
        chk("t3_owner0", bus.owner, 1'b0);

        // master holds valid two extra cycles after ack
        quiesce();
        hold_fix = 2; req_pct = 100;
        auto_m[0] = 1'b1;
        wait_busy(1'b1, 20, "t4_grant");
        cnt = 0;
        for (int n = 0; n < 20 && bus.busy; n++) begin
            if (bus.m0_valid && bus.m0_ready && !bus.s_valid) cnt++;
            @(negedge clk);
        end
        chk("t4_hold_cycles", cnt, 2);
        quiesce();
        hold_fix = 0;

        // dead slave: watchdog abort, sticky error, clear, then normal service
        s_pct = 0;
        cyc();
        set_m(0, 1'b1, 1'b0, 16'h3000, 8'h00);
        @(negedge clk);
        for (int n = 0; n < TMO; n++) begin
            @(negedge clk);
            chk("t5_stall", {bus.s_valid, bus.m0_ready}, 2'b10);
        end
        @(negedge clk);
        chk("t5_abt_ready", bus.m0_ready, 1'b1);
        chk("t5_abt_rdata", bus.m0_rdata, 8'hFF);
        chk("t5_err_set", bus.err, 1'b1);
        cyc();
        set_v(0, 1'b0);
        wait_busy(1'b0, 6, "t5_idle");
        chk("t5_err_sticky", bus.err, 1'b1);
        cyc();
        bus.err_clr = 1'b1;
        cyc();
        bus.err_clr = 1'b0;
        @(negedge clk);
        chk("t5_err_clr", bus.err, 1'b0);
        s_pct = 100; req_pct = 100;
        auto_m[1] = 1'b1;
        cnt = 0;
        for (int n = 0; n < 10 && !bus.m1_ready; n++) @(negedge clk);
        chk("t5_served", bus.m1_ready, 1'b1);
        chk("t5_no_err", bus.err, 1'b0);

        // reset in the middle of a request
        quiesce();
        s_pct = 0;
        cyc();
        set_m(0, 1'b1, 1'b0, 16'h4000, 8'h00);
        repeat (3) cyc();
        rstb = 1'b0;
        #1;
        chk("t6_rst_outs", {bus.s_valid, bus.m0_ready, bus.m1_ready, bus.busy}, 4'b0000);
        chk("t6_rst_owner", bus.owner, 1'b1);
        set_m(1, 1'b1, 1'b0, 16'h5000, 8'h00);
        cyc();
        rstb = 1'b1;
        s_pct = 100;
        wait_busy(1'b1, 4, "t6_grant");
        chk("t6_owner", bus.owner, 1'b0);
        for (int n = 0; n < 10 && !bus.m0_ready; n++) @(negedge clk);
        chk("t6_ack", bus.m0_ready, 1'b1);
        cyc();
        set_v(0, 1'b0);
        set_v(1, 1'b0);
        wait_busy(1'b0, 10, "t6_idle");

        // randomized traffic
        quiesce();
        fix_pl = 1'b0; hold_fix = -1;
        auto_m[0] = 1'b1; auto_m[1] = 1'b1;
        for (int n = 0; n < 2000; n++) begin
            if (n % 100 == 0) begin
                s_pct   = int'($urandom_range(20, 95));
                req_pct = int'($urandom_range(10, 90));
            end
            bus.err_clr = ($urandom_range(19) == 0);
            cyc();
        end
        bus.err_clr = 1'b0;
        quiesce();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
